// File: rtl/systolic_pkg.sv
// ---------------------------------------------------------------------------
// systolic_pkg
// Shared definitions for the 3x3 systolic multiply sequencer:
//   N             - array dimension (3 is the only supported size)
//   FEED_CYCLES   - cycles spent driving skewed operands (2N-1)
//   DRAIN_CYCLES  - cycles spent flushing the pass registers (N-1)
//   state_t       - sequencer state encoding
//   flat_idx()    - row-major index of element (row, col) in a flat matrix
// ---------------------------------------------------------------------------
package systolic_pkg;

    localparam int N            = 3;
    localparam int FEED_CYCLES  = 2 * N - 1;
    localparam int DRAIN_CYCLES = N - 1;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CLEAR = 3'd1,
        FEED  = 3'd2,
        DRAIN = 3'd3,
        DONE  = 3'd4
    } state_t;

    function automatic int flat_idx(input int row, input int col);
        return row * N + col;
    endfunction

endpackage

// File: rtl/systolic_skew_feed.sv
// ---------------------------------------------------------------------------
// systolic_skew_feed
// Combinational operand skewing for the array edges. At step t, row lane i
// carries A[i][t-i] and column lane j carries B[t-j][j]; out-of-range
// indices (and en=0) give zero.
// Ports:
//   a_ops, b_ops          - latched operands, row-major, N*N*DATA_W bits
//   t                     - current feed step
//   en                    - feed enable; lanes are zero when low
//   row_lanes, col_lanes  - N lanes of DATA_W bits, lane 0 in the LSBs
// ---------------------------------------------------------------------------
module systolic_skew_feed
    import systolic_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic [N*N*DATA_W-1:0] a_ops,
    input  logic [N*N*DATA_W-1:0] b_ops,
    input  logic [2:0]            t,
    input  logic                  en,
    output logic [N*DATA_W-1:0]   row_lanes,
    output logic [N*DATA_W-1:0]   col_lanes
);

    // Lane/element select: exactly one k satisfies t == lane + k when in range,
    // so OR-accumulating the masked candidates acts as the mux.
    always_comb begin
        row_lanes = '0;
        col_lanes = '0;
        for (int lane = 0; lane < N; lane++) begin
            for (int k = 0; k < N; k++) begin
                row_lanes[lane*DATA_W +: DATA_W] = row_lanes[lane*DATA_W +: DATA_W] |
                    ((en && (int'(t) == lane + k)) ? a_ops[flat_idx(lane, k)*DATA_W +: DATA_W]
                                                    : {DATA_W{1'b0}});
                col_lanes[lane*DATA_W +: DATA_W] = col_lanes[lane*DATA_W +: DATA_W] |
                    ((en && (int'(t) == lane + k)) ? b_ops[flat_idx(k, lane)*DATA_W +: DATA_W]
                                                    : {DATA_W{1'b0}});
            end
        end
    end

endmodule

// File: rtl/systolic_seq_ctrl.sv
// ---------------------------------------------------------------------------
// systolic_seq_ctrl
// Sequencer for an external 3x3 output-stationary systolic MAC array.
// One run: IDLE -(start)-> CLEAR (1) -> FEED (t=0..4) -> DRAIN (t=5,6) -> DONE.
// Feeds and mac_clr are registered from the next state so the array sees
// them in the same cycle the state is current. The last accumulate lands on
// the edge ending t=6, so res_in is captured on the first edge spent in DONE
// and done/result appear together in the following cycle.
// Ports:
//   clk, rst_n           - clock, asynchronous active-low reset
//   start                - run request, honoured only in IDLE when not busy
//   a_flat, b_flat       - operands, row-major, latched on start acceptance
//   row_feed, col_feed   - skewed array edge inputs
//   mac_clr              - clears array accumulators and pass registers
//   res_in               - array accumulator outputs, row-major
//   result               - captured product C = A*B (mod 2^DATA_W)
//   busy, done           - run in progress / result valid
//   res_ack              - result consumed (only with SYS_SEQ_ACK_EN)
// Build option: define SYS_SEQ_ACK_EN to hold done until res_ack; otherwise
// done is a single-cycle pulse and res_ack is ignored.
// ---------------------------------------------------------------------------
module systolic_seq_ctrl #(
    parameter int DATA_W = 8,
    parameter int N      = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [N*N*DATA_W-1:0] a_flat,
    input  logic [N*N*DATA_W-1:0] b_flat,
    output logic [N*DATA_W-1:0]   row_feed,
    output logic [N*DATA_W-1:0]   col_feed,
    output logic                  mac_clr,
    input  logic [N*N*DATA_W-1:0] res_in,
    output logic [N*N*DATA_W-1:0] result,
    output logic                  busy,
    output logic                  done,
    input  logic                  res_ack
);

    import systolic_pkg::*;

    localparam logic [2:0] T_FEED_LAST  = 3'(FEED_CYCLES - 1);
    localparam logic [2:0] T_DRAIN_LAST = 3'(FEED_CYCLES + DRAIN_CYCLES - 1);

    state_t                  state_r, state_s;
    logic [2:0]              t_r, t_s;
    logic                    accept_s, capture_s, feed_en_s, done_s, busy_s;
    logic [N*N*DATA_W-1:0]   a_r, b_r, result_r;
    logic [N*DATA_W-1:0]     row_lanes_s, col_lanes_s, row_feed_r, col_feed_r;
    logic                    mac_clr_r, busy_r, done_r;

`ifndef SYS_SEQ_ACK_EN
    logic unused_s;
    assign unused_s = res_ack;
`endif

    // State and step-counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
            t_r     <= 3'd0;
        end else begin
            state_r <= state_s;
            t_r     <= t_s;
        end
    end

    // Next-state and step-counter logic.
    always_comb begin
        state_s  = state_r;
        t_s      = t_r;
        accept_s = 1'b0;
        case (state_r)
            IDLE: begin
                // busy_r is still high in the cycle done is shown; a start
                // there belongs to the finished run and is dropped.
                if (start && !busy_r) begin
                    accept_s = 1'b1;
                    state_s  = CLEAR;
                    t_s      = 3'd0;
                end else begin
                    state_s = IDLE;
                    t_s     = 3'd0;
                end
            end
            CLEAR: begin
                state_s = FEED;
                t_s     = 3'd0;
            end
            FEED: begin
                t_s = t_r + 3'd1;
                if (t_r == T_FEED_LAST) begin
                    state_s = DRAIN;
                end else begin
                    state_s = FEED;
                end
            end
            DRAIN: begin
                if (t_r == T_DRAIN_LAST) begin
                    state_s = DONE;
                    t_s     = 3'd0;
                end else begin
                    state_s = DRAIN;
                    t_s     = t_r + 3'd1;
                end
            end
            DONE: begin
                t_s = 3'd0;
`ifdef SYS_SEQ_ACK_EN
                if (res_ack && done_r) begin
                    state_s = IDLE;
                end else begin
                    state_s = DONE;
                end
`else
                state_s = IDLE;
`endif
            end
            default: begin
                state_s = IDLE;
                t_s     = 3'd0;
            end
        endcase
    end

    // Output decode; done/busy lag the DONE state by one edge so that they
    // rise together with the captured result.
    always_comb begin
        feed_en_s = (state_s == FEED);
        capture_s = (state_r == DONE) && !done_r;
`ifdef SYS_SEQ_ACK_EN
        done_s    = (state_r == DONE) && !(res_ack && done_r);
`else
        done_s    = (state_r == DONE);
`endif
        busy_s    = (state_s != IDLE) || done_s;
    end

    systolic_skew_feed #(
        .DATA_W (DATA_W)
    ) u_skew (
        .a_ops     (a_r),
        .b_ops     (b_r),
        .t         (t_s),
        .en        (feed_en_s),
        .row_lanes (row_lanes_s),
        .col_lanes (col_lanes_s)
    );

    // Operand latch, registered array controls, result capture and status.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_r        <= '0;
            b_r        <= '0;
            row_feed_r <= '0;
            col_feed_r <= '0;
            mac_clr_r  <= 1'b0;
            result_r   <= '0;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
        end else begin
            if (accept_s) begin
                a_r <= a_flat;
                b_r <= b_flat;
            end
            row_feed_r <= row_lanes_s;
            col_feed_r <= col_lanes_s;
            mac_clr_r  <= (state_s == CLEAR);
            if (capture_s) begin
                result_r <= res_in;
            end
            busy_r <= busy_s;
            done_r <= done_s;
        end
    end

    assign row_feed = row_feed_r;
    assign col_feed = col_feed_r;
    assign mac_clr  = mac_clr_r;
    assign result   = result_r;
    assign busy     = busy_r;
    assign done     = done_r;

endmodule

// File: tb/tb_systolic_seq_ctrl.sv
// ---------------------------------------------------------------------------
// tb_systolic_seq_ctrl
// Drives systolic_seq_ctrl against a behavioural 3x3 MAC array and checks
// results against a direct matrix product. Honours SYS_SEQ_ACK_EN.
// ---------------------------------------------------------------------------
module tb_systolic_seq_ctrl;

    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          rst_n, start, res_ack;
    logic [71:0]   a_flat, b_flat, res_in, result;
    logic [23:0]   row_feed, col_feed;
    logic          mac_clr, busy, done;

    int            n_checks = 0;
    int            n_fail   = 0;
    logic [71:0]   exp_q[$];
    logic          done_q = 1'b0;

    always #5 clk = ~clk;

    systolic_seq_ctrl #(.DATA_W(DW), .N(3)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .a_flat(a_flat), .b_flat(b_flat),
        .row_feed(row_feed), .col_feed(col_feed), .mac_clr(mac_clr), .res_in(res_in),
        .result(result), .busy(busy), .done(done), .res_ack(res_ack)
    );

    // Behavioural output-stationary array: one accumulate/pass per edge.
    logic [7:0] acc [3][3] = '{default: 8'd0};
    logic [7:0] pa  [3][3] = '{default: 8'd0};
    logic [7:0] pb  [3][3] = '{default: 8'd0};

    function automatic logic [7:0] a_in(input int i, input int j);
        if (j == 0) return row_feed[i*8 +: 8];
        else        return pa[i][(j > 0) ? j - 1 : 0];
    endfunction

    function automatic logic [7:0] b_in(input int i, input int j);
        if (i == 0) return col_feed[j*8 +: 8];
        else        return pb[(i > 0) ? i - 1 : 0][j];
    endfunction

    always @(posedge clk) begin
        for (int i = 0; i < 3; i++) begin
            for (int j = 0; j < 3; j++) begin
                if (mac_clr) begin
                    acc[i][j] <= 8'd0;
                    pa[i][j]  <= 8'd0;
                    pb[i][j]  <= 8'd0;
                end else begin
                    acc[i][j] <= acc[i][j] + a_in(i, j) * b_in(i, j);
                    pa[i][j]  <= a_in(i, j);
                    pb[i][j]  <= b_in(i, j);
                end
            end
        end
    end

    always_comb begin
        res_in = '0;
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++)
                res_in[(3*i + j)*8 +: 8] = acc[i][j];
    end

    task automatic chk(input string tag, input logic [71:0] obs, input logic [71:0] exp_v);
        n_checks++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    function automatic logic [71:0] matmul(input logic [71:0] a, input logic [71:0] b);
        logic [71:0] c;
        logic [7:0]  s;
        c = '0;
        for (int i = 0; i < 3; i++) begin
            for (int j = 0; j < 3; j++) begin
                s = 8'd0;
                for (int k = 0; k < 3; k++)
                    s = s + a[(3*i + k)*8 +: 8] * b[(3*k + j)*8 +: 8];
                c[(3*i + j)*8 +: 8] = s;
            end
        end
        return c;
    endfunction

    function automatic logic [23:0] exp_row(input logic [71:0] a, input int t);
        logic [23:0] r;
        r = '0;
        for (int i = 0; i < 3; i++)
            if (t - i >= 0 && t - i < 3) r[i*8 +: 8] = a[(3*i + t - i)*8 +: 8];
        return r;
    endfunction

    function automatic logic [23:0] exp_col(input logic [71:0] b, input int t);
        logic [23:0] r;
        r = '0;
        for (int j = 0; j < 3; j++)
            if (t - j >= 0 && t - j < 3) r[j*8 +: 8] = b[(3*(t - j) + j)*8 +: 8];
        return r;
    endfunction

    function automatic logic [71:0] fill(input logic [7:0] v);
        logic [71:0] m;
        for (int e = 0; e < 9; e++) m[e*8 +: 8] = v;
        return m;
    endfunction

    function automatic logic [71:0] ident();
        logic [71:0] m;
        m = '0;
        for (int i = 0; i < 3; i++) m[(4*i)*8 +: 8] = 8'd1;
        return m;
    endfunction

    function automatic logic [71:0] seq9();
        logic [71:0] m;
        for (int e = 0; e < 9; e++) m[e*8 +: 8] = 8'(e + 1);
        return m;
    endfunction

    // Scoreboard: each rising done pops one expected product.
    always @(negedge clk) begin
        if (done === 1'b1 && done_q !== 1'b1) begin
            if (exp_q.size() == 0) chk("unexpected_done", 72'd1, 72'd0);
            else                   chk("result", result, exp_q.pop_front());
        end
        done_q <= done;
    end

    // One job: cycle k is the one following edge k, where edge 0 samples start.
    task automatic run_job(input logic [71:0] a, input logic [71:0] b,
                           input int inj_k, input int rst_k);
        logic [71:0] exp_v;
        int  k, dcount;
        bit  got, aborted;
        exp_v = matmul(a, b);
        got = 1'b0; aborted = 1'b0; k = 0;
        @(negedge clk);
        a_flat = a; b_flat = b; start = 1'b1;
        if (rst_k < 0) exp_q.push_back(exp_v);
        while (!got && !aborted && k < 40) begin
            @(negedge clk);
            if (k == 0) begin
                start = 1'b0; a_flat = ~a; b_flat = ~b;
            end
            if (k == inj_k) begin
                start = 1'b1; a_flat = fill(8'd2); b_flat = fill(8'd3);
            end else if (k == inj_k + 1) begin
                start = 1'b0;
            end
            if (k <= 8) begin
                chk("busy_run", 72'(busy), 72'd1);
                chk("mac_clr", 72'(mac_clr), 72'(k == 0));
                chk("row_feed", 72'(row_feed), 72'(exp_row(a, k - 1)));
                chk("col_feed", 72'(col_feed), 72'(exp_col(b, k - 1)));
            end
            if (k == rst_k) begin
                rst_n = 1'b0;
                #1;
                chk("rst_busy", 72'(busy), 72'd0);
                chk("rst_done", 72'(done), 72'd0);
                chk("rst_mac_clr", 72'(mac_clr), 72'd0);
                chk("rst_feeds", 72'({row_feed, col_feed}), 72'd0);
                chk("rst_result", result, 72'd0);
                @(negedge clk);
                rst_n = 1'b1;
                aborted = 1'b1;
            end else if (done === 1'b1) begin
                got = 1'b1;
                chk("latency", 72'(k), 72'd9);
            end
            k++;
        end
        if (!got && !aborted) chk("done_timeout", 72'd0, 72'd1);
        if (aborted) begin
            repeat (15) begin
                @(negedge clk);
                chk("no_done_after_abort", 72'(done), 72'd0);
            end
        end
        if (got) begin
`ifdef SYS_SEQ_ACK_EN
            dcount = 1;
            for (int w = 0; w < 20; w++) begin
                @(negedge clk);
                if (done === 1'b1) begin
                    dcount++;
                    if (dcount == 5) res_ack = 1'b1;
                end else begin
                    break;
                end
            end
            res_ack = 1'b0;
            chk("done_hold_cycles", 72'(dcount), 72'd5);
`else
            @(negedge clk);
            dcount = 1;
`endif
            chk("done_fall", 72'(done), 72'd0);
            chk("busy_fall", 72'(busy), 72'd0);
            repeat (3) @(negedge clk);
            chk("result_hold", result, exp_v);
            if (inj_k >= 0) begin
                repeat (12) @(negedge clk);
                chk("no_queued_start", 72'(busy | done), 72'd0);
            end
        end
    endtask

    initial begin
        logic [71:0] ra, rb;
        rst_n = 1'b0; start = 1'b0; res_ack = 1'b0;
        a_flat = '0; b_flat = '0;
        repeat (3) @(negedge clk);
        chk("reset_busy", 72'(busy), 72'd0);
        chk("reset_done", 72'(done), 72'd0);
        chk("reset_mac_clr", 72'(mac_clr), 72'd0);
        chk("reset_row_feed", 72'(row_feed), 72'd0);
        chk("reset_col_feed", 72'(col_feed), 72'd0);
        chk("reset_result", result, 72'd0);
        rst_n = 1'b1;
        @(negedge clk);

        run_job(ident(), seq9(), -1, -1);
        chk("identity_product", result, seq9());
        run_job(fill(8'd1), fill(8'd1), -1, -1);
        chk("ones_product", result, fill(8'd3));
        run_job(fill(8'd16), fill(8'd16), -1, -1);
        chk("wrap_product", result, fill(8'd0));
        run_job(seq9(), fill(8'd1), 3, -1);
        run_job(fill(8'd9), seq9(), -1, 4);
        run_job(ident(), ident(), -1, -1);
        chk("post_abort_identity", result, ident());
        for (int e = 0; e < 9; e++) begin
            ra[e*8 +: 8] = 8'($urandom_range(255, 0));
            rb[e*8 +: 8] = 8'($urandom_range(255, 0));
        end
        run_job(ra, rb, -1, -1);

        chk("scoreboard_empty", 72'(exp_q.size()), 72'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/systolic_seq_ctrl.md
SYSTOLIC_SEQ_CTRL -- requirements
Module: systolic_seq_ctrl

Interface
REQ-001 SHALL have parameter DATA_W, default 8: operand, result and feed-lane width.
REQ-002 SHALL have parameter N, default 3: array dimension; only N=3 is supported.
REQ-003 SHALL use one clock, clk; reset is asynchronous and active-low (rst_n).
REQ-004 clk  input  1  rising-edge clock for all state.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 start  input  1  request to run one 3x3 multiply; sampled only in IDLE.
REQ-007 a_flat  input  9*DATA_W  matrix A, row-major; element (i,j) at bits [(3i+j)*DATA_W +: DATA_W].
REQ-008 b_flat  input  9*DATA_W  matrix B, same packing as a_flat.
REQ-009 row_feed  output  3*DATA_W  array row inputs; lane i drives row i.
REQ-010 col_feed  output  3*DATA_W  array column inputs; lane j drives column j.
REQ-011 mac_clr  output  1  synchronous clear of all MAC accumulators and pass registers.
REQ-012 res_in  input  9*DATA_W  array accumulator outputs, row-major.
REQ-013 result  output  9*DATA_W  captured product C = A*B.
REQ-014 busy  output  1  high from start acceptance until the end of DONE.
REQ-015 done  output  1  result valid.
REQ-016 res_ack  input  1  result consumed; used only when SYS_SEQ_ACK_EN is defined.

Function
REQ-017 States SHALL be IDLE, CLEAR, FEED, DRAIN, DONE; step counter t is 3 bits.
REQ-018 IDLE with start=1 SHALL latch a_flat/b_flat into internal registers and go to CLEAR; operand inputs are ignored at all other times.
REQ-019 CLEAR SHALL last 1 cycle with mac_clr=1 and all feed lanes 0, then go to FEED with t=0.
REQ-020 FEED SHALL last 5 cycles (t=0..4); row lane i = A[i][t-i] and column lane j = B[t-j][j] when 0<=t-i<3 (resp. t-j), else 0.
REQ-021 DRAIN SHALL last 2 cycles (t=5,6) with all lanes 0, then go to DONE.
REQ-022 On entry to DONE, result SHALL capture res_in (the MAC contract is one registered accumulate/pass per edge, so C[2][2] is final after the edge ending t=6).
REQ-023 Start-to-done latency SHALL be 9 cycles: start sampled at edge 0, done high in the cycle following edge 9.
REQ-024 Arithmetic SHALL be modulo 2^DATA_W; result is res_in verbatim, with no saturation.
REQ-025 start while busy SHALL be ignored and SHALL NOT be queued.
REQ-026 mac_clr SHALL be 0 in every state other than CLEAR.

Reset
REQ-027 While rst_n=0: state=IDLE, t=0, busy=0, done=0, mac_clr=0, feeds=0, result=0, operand registers=0.
REQ-028 Reset asserted mid-operation SHALL abort the run; no done is produced and the next start runs normally, with CLEAR removing stale accumulator state.

Configuration
REQ-029 Macro SYS_SEQ_ACK_EN defined: DONE SHALL hold done=1 and busy=1 until res_ack=1, then return to IDLE the next cycle; result is held stable.
REQ-030 Macro SYS_SEQ_ACK_EN undefined: DONE SHALL last exactly 1 cycle, then return to IDLE; res_ack is ignored; result is held until the next capture.

Structure
REQ-031 Package systolic_pkg SHALL hold N, FEED_CYCLES=2N-1, DRAIN_CYCLES=N-1, the state enum and the flat-index helper.
REQ-032 Sub-module systolic_skew_feed SHALL generate the skewed row/col lanes from the latched operands, t, and a feed-enable.

Verification
REQ-033 A=identity, B=1..9 row-major -> result = 1..9; done 9 cycles after start.
REQ-034 A=all 1, B=all 1 -> every result element = 3.
REQ-035 A=all 16, B=all 16 -> every element = 768 mod 256 = 0 (wrap).
REQ-036 start pulsed at t=2 of FEED with different operands -> ignored; result from the first operands only.
REQ-037 rst_n low at FEED t=3, then start with A=B=identity -> no done for the aborted run; result = identity.
REQ-038 SYS_SEQ_ACK_EN defined, res_ack delayed 4 cycles -> done/busy high for 5 cycles, then IDLE; undefined -> done is a 1-cycle pulse.
